// File: rtl/lfsr_keystream_4bit.sv
// lfsr_keystream_4bit
// Keystream source for the key operand (y) of the 4-bit bitwise XOR stage.
// A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances four steps per
// accepted transfer and presents its low nibble as the key. A valid/ready
// handshake faces the consumer. A seed can be loaded at any time, and an
// all-zero seed locks the block in an error state until a nonzero seed arrives.
//
// Build option: define KEYSTREAM_COUNT_EN to add the 16-bit key_count output,
// which counts completed transfers.
module lfsr_keystream_4bit #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        start,
    input  logic        stop,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [3:0]  key,
    output logic        busy,
    output logic        zero_err
`ifdef KEYSTREAM_COUNT_EN
    ,
    output logic [15:0] key_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] lfsr_adv;
    logic        xfer;

    // One LFSR step: taps 16/14/13/11 feed back into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Four unrolled LFSR steps, i.e. one full advance to a fresh nibble.
    always_comb begin
        lfsr_adv = lfsr;
        for (int unsigned i = 0; i < 4; i++) begin
            lfsr_adv = lfsr_step(lfsr_adv);
        end
    end

    // Outputs decode straight from the state and LFSR flops.
    assign key_valid = (state == ST_RUN);
    assign busy      = (state == ST_RUN);
    assign zero_err  = (state == ST_ERR);
    assign key       = lfsr[3:0];
    assign xfer      = key_valid & key_ready;

    // Next state and next LFSR value; seed_load overrides everything.
    // A transfer coinciding with seed_load is consumed but does not advance.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        if (seed_load) begin
            lfsr_nxt  = seed;
            state_nxt = (seed == '0) ? ST_ERR : ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        lfsr_nxt = lfsr_adv;
                    end
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state_nxt = ST_ERR;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and LFSR registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            lfsr  <= SEED_DEFAULT;
        end else begin
            state <= state_nxt;
            lfsr  <= lfsr_nxt;
        end
    end

`ifdef KEYSTREAM_COUNT_EN
    // Transfer counter; survives seed_load, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_count <= '0;
        end else if (xfer) begin
            key_count <= key_count + 16'd1;
        end
    end
`else
    // No transfer counter in this build.
`endif

endmodule

// File: tb/tb_lfsr_keystream_4bit.sv
// tb_lfsr_keystream_4bit
// Directed bench for lfsr_keystream_4bit with hand-computed key values.
// Define KEYSTREAM_COUNT_EN for both bench and RTL to cover key_count.
`timescale 1ns/1ps
module tb_lfsr_keystream_4bit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        start;
    logic        stop;
    logic        key_ready;
    logic        key_valid;
    logic [3:0]  key;
    logic        busy;
    logic        zero_err;
`ifdef KEYSTREAM_COUNT_EN
    logic [15:0] key_count;
`endif

    int total = 0;
    int bad   = 0;

    lfsr_keystream_4bit #(.SEED_DEFAULT(16'hACE1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_load (seed_load),
        .seed      (seed),
        .start     (start),
        .stop      (stop),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key       (key),
        .busy      (busy),
        .zero_err  (zero_err)
`ifdef KEYSTREAM_COUNT_EN
        ,
        .key_count (key_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;
        start     = 1'b0;
        stop      = 1'b0;
        key_ready = 1'b0;
        step();
        step();
        chk("rst_valid", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", zero_err, 0);
        chk("rst_key", key, 4'h1);
        chk("rst_lfsr", dut.lfsr, 16'hACE1);
`ifdef KEYSTREAM_COUNT_EN
        chk("rst_cnt", key_count, 0);
`endif
        reset_n = 1'b1;

        // stop in IDLE is ignored
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("idle_stop_busy", busy, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_valid", key_valid, 1);
        chk("run_busy", busy, 1);
        chk("run_key0", key, 4'h1);

        // Hold: no transfer, no advance
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", key_valid, 1);
            chk("hold_key", key, 4'h1);
        end

        // Single transfer: ACE1 -> 59C3 -> B387 -> 670F -> CE1E
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        chk("adv1_key", key, 4'hE);
        chk("adv1_lfsr", dut.lfsr, 16'hCE1E);
        step();
        chk("adv1_hold", key, 4'hE);

        // Back-to-back transfers: CE1E -> E1E4 -> 1E45
        key_ready = 1'b1;
        step();
        chk("adv2_key", key, 4'h4);
        chk("adv2_lfsr", dut.lfsr, 16'hE1E4);
        step();
        chk("adv3_key", key, 4'h5);
        chk("adv3_lfsr", dut.lfsr, 16'h1E45);
`ifdef KEYSTREAM_COUNT_EN
        chk("cnt3", key_count, 3);
`endif

        // stop with concurrent transfer: completes one advance to E455
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_valid", key_valid, 0);
        chk("stop_key", key, 4'h5);
        chk("stop_lfsr", dut.lfsr, 16'hE455);
        step();
        step();
        chk("idle_noadv", dut.lfsr, 16'hE455);
        chk("idle_valid", key_valid, 0);
        key_ready = 1'b0;
`ifdef KEYSTREAM_COUNT_EN
        chk("cnt_stop", key_count, 4);
`endif

        // start+stop together: start wins in IDLE, stop wins in RUN
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("both_idle", busy, 1);
        step();
        chk("both_run", busy, 0);
        start = 1'b0;
        stop  = 1'b0;

        // Zero seed -> ERR lockout
        seed_load = 1'b1;
        seed      = 16'h0000;
        step();
        seed_load = 1'b0;
        chk("err_flag", zero_err, 1);
        chk("err_key", key, 4'h0);
        chk("err_valid", key_valid, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_start", zero_err, 1);
        chk("err_busy", busy, 0);

        // Recovery with nonzero seed
        seed_load = 1'b1;
        seed      = 16'hACE1;
        step();
        seed_load = 1'b0;
        chk("rec_err", zero_err, 0);
        chk("rec_key", key, 4'h1);
        chk("rec_busy", busy, 0);

        // seed_load during RUN with concurrent transfer: no advance, -> IDLE
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run2_busy", busy, 1);
        key_ready = 1'b1;
        seed_load = 1'b1;
        seed      = 16'h1234;
        step();
        seed_load = 1'b0;
        key_ready = 1'b0;
        chk("ld_run_key", key, 4'h4);
        chk("ld_run_lfsr", dut.lfsr, 16'h1234);
        chk("ld_run_valid", key_valid, 0);
`ifdef KEYSTREAM_COUNT_EN
        chk("cnt_ld", key_count, 5);
`endif

        // Reset mid-RUN with key_ready held high
        start = 1'b1;
        step();
        start = 1'b0;
        key_ready = 1'b1;
        step();
        reset_n = 1'b0;
        step();
        chk("rrst_valid", key_valid, 0);
        chk("rrst_key", key, 4'h1);
        chk("rrst_busy", busy, 0);
`ifdef KEYSTREAM_COUNT_EN
        chk("rrst_cnt", key_count, 0);
`endif
        reset_n   = 1'b1;
        key_ready = 1'b0;

        // Full period: 65535 advances of 4 steps return to the seed
        start = 1'b1;
        step();
        start = 1'b0;
        key_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        chk("period_lfsr", dut.lfsr, 16'hACE1);
        chk("period_key", key, 4'h1);
`ifdef KEYSTREAM_COUNT_EN
        chk("cnt_max", key_count, 16'hFFFF);
`endif
        step();
        chk("wrap_key", key, 4'hE);
`ifdef KEYSTREAM_COUNT_EN
        chk("cnt_wrap", key_count, 0);
`endif
        key_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
